// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial link (transmitter now, receiver later).
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..DIV-1 while enabled and flags the wrap cycle with tick.
module bit_timer #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset_L,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int            TW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] LAST = TW'(DIV - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;
  logic          at_wrap;

  assign at_wrap = (count_q == LAST);
  assign tick    = en & at_wrap;

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      if (at_wrap) begin
        count_d = '0;
      end else begin
        count_d = count_q + TW'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start, data LSB first, optional even parity, stop.
// Optional parity bit is enabled by defining SERIAL_TX_PARITY_EN.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             serial_out_q, serial_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;
  tx_state_t        after_data;

`ifdef SERIAL_TX_PARITY_EN
  logic parity_q, parity_d;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  assign after_data = PARITY;
`else
  assign after_data = STOP;
`endif

  // The timer is held at zero in IDLE so every frame starts on a fresh bit period.
  bit_timer #(.DIV(DIV)) u_timer (
    .clock   (clock),
    .reset_L (reset_L),
    .en      (busy_q),
    .clear   (state_q == IDLE),
    .tick    (tick)
  );

  // Next-state, shift register and bit counter.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d   = START;
          shift_d   = data;
          bit_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = after_data;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    busy_d       = (state_d != IDLE);
    serial_out_d = LINE_IDLE;
    case (state_d)
      IDLE:   serial_out_d = LINE_IDLE;
      START:  serial_out_d = START_LEVEL;
      DATA:   serial_out_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY: serial_out_d = parity_q;
`endif
      STOP:   serial_out_d = STOP_LEVEL;
      default: serial_out_d = LINE_IDLE;
    endcase
  end

`ifdef SERIAL_TX_PARITY_EN
  // Parity is computed once from the word at the accepting edge.
  always_comb begin
    if ((state_q == IDLE) && valid) begin
      parity_d = even_parity(data);
    end else begin
      parity_d = parity_q;
    end
  end

  // Parity register.
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      serial_out_q <= LINE_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      serial_out_q <= serial_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign ready      = ~busy_q;
  assign serial_out = serial_out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: frame-level reference model plus directed literal checks.
module tb_serial_tx;

  localparam int WIDTH = 8;
  localparam int DIV   = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int          P         = 1;
  localparam logic [15:0] A5_EXP    = 16'h054A;
  localparam logic [15:0] DIV1_EXP  = 16'h0700;
`else
  localparam int          P         = 0;
  localparam logic [15:0] A5_EXP    = 16'h034A;
  localparam logic [15:0] DIV1_EXP  = 16'h0300;
`endif
  localparam int NB = WIDTH + 2 + P;
  localparam int FL = NB * DIV;

  logic       clock   = 1'b0;
  logic       reset_L = 1'b0;
  logic [7:0] data    = 8'h00;
  logic       valid   = 1'b0;
  logic       ready, serial_out, busy, done;
  logic [7:0] data1   = 8'h00;
  logic       valid1  = 1'b0;
  logic       ready1, serial_out1, busy1, done1;

  always #5 clock = ~clock;

  serial_tx #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clock(clock), .reset_L(reset_L), .data(data), .valid(valid),
    .ready(ready), .serial_out(serial_out), .busy(busy), .done(done)
  );

  serial_tx #(.WIDTH(WIDTH), .DIV(1)) dut1 (
    .clock(clock), .reset_L(reset_L), .data(data1), .valid(valid1),
    .ready(ready1), .serial_out(serial_out1), .busy(busy1), .done(done1)
  );

  int vectors     = 0;
  int miscompares = 0;
  int dut_dones   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as a bit list: index 0 is the start bit, then data LSB first, parity, stop.
  function automatic logic [15:0] make_frame(input logic [7:0] d);
    logic [15:0] f;
    f      = 16'hFFFF;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (P == 1) f[9] = ^d;
    return f;
  endfunction

  logic        m_busy   = 1'b0;
  logic        m_done   = 1'b0;
  int          m_pos    = 0;
  int          m_frames = 0;
  logic [15:0] m_frame  = 16'hFFFF;
  logic        chk_en   = 1'b0;

  always @(posedge clock) begin
    if (!reset_L) begin
      m_busy <= 1'b0;
      m_pos  <= 0;
      m_done <= 1'b0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (valid) begin
        m_busy  <= 1'b1;
        m_pos   <= 0;
        m_frame <= make_frame(data);
      end
    end else if (m_pos == FL - 1) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b1;
      m_frames <= m_frames + 1;
    end else begin
      m_pos  <= m_pos + 1;
      m_done <= 1'b0;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("serial_out", 32'(serial_out), 32'(m_busy ? m_frame[m_pos / DIV] : 1'b1));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("ready", 32'(ready), 32'(!m_busy));
      chk("done", 32'(done), 32'(m_done));
      if (done) dut_dones++;
    end
  end

  // Samples one bit per period from the current negedge until done (bounded).
  task automatic capture(input int glitch_k, output logic [15:0] lv,
                         output int done_k, output int ready_hi);
    lv       = '0;
    done_k   = -1;
    ready_hi = 0;
    for (int k = 0; k < 20 * FL; k++) begin
      if ((k % DIV == 0) && (k / DIV < NB)) lv[k / DIV] = serial_out;
      if (done) begin
        done_k = k;
        break;
      end
      if (ready) ready_hi++;
      if (glitch_k >= 0 && k == glitch_k) begin
        valid = 1'b1;
        data  = 8'hFF;
      end else if (glitch_k >= 0 && k == glitch_k + 1) begin
        valid = 1'b0;
      end
      @(negedge clock);
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input int glitch_k, output logic [15:0] lv,
                           output int done_k, output int ready_hi);
    @(negedge clock);
    valid = 1'b1;
    data  = d;
    @(negedge clock);
    valid = 1'b0;
    data  = 8'($urandom);
    capture(glitch_k, lv, done_k, ready_hi);
  endtask

  initial begin
    logic [15:0] lv, lv2, lv1;
    int dk, dk2, rh, cnt_busy, cnt_done, cnt_low;

    reset_L = 1'b0;
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    chk("rst_serial", 32'(serial_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    reset_L = 1'b1;

    run_frame(8'hA5, -1, lv, dk, rh);
    chk("a5_levels", 32'(lv), 32'(A5_EXP));
    chk("a5_done_k", 32'(dk), 32'(FL));
    chk("a5_ready_low", 32'(rh), 32'd0);

`ifdef SERIAL_TX_PARITY_EN
    run_frame(8'h07, -1, lv, dk, rh);
    chk("par07_bit", 32'(lv[9]), 32'd1);
    chk("par07_len", 32'(dk), 32'd44);
    run_frame(8'h03, -1, lv, dk, rh);
    chk("par03_bit", 32'(lv[9]), 32'd0);
    chk("par03_len", 32'(dk), 32'd44);
`endif

    run_frame(8'h3C, DIV * 3, lv, dk, rh);
    chk("3c_data", 32'(lv[8:1]), 32'h3C);
    chk("3c_done_k", 32'(dk), 32'(FL));
    cnt_busy = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      @(negedge clock);
      if (busy) cnt_busy++;
    end
    chk("3c_no_second", 32'(cnt_busy), 32'd0);

    @(negedge clock);
    valid = 1'b1;
    data  = 8'h00;
    @(negedge clock);
    data = 8'hFF;
    capture(-1, lv, dk, rh);
    chk("b2b_f1_data", 32'(lv[8:1]), 32'h00);
    chk("b2b_f1_len", 32'(dk), 32'(FL));
    chk("b2b_gap_high", 32'(serial_out), 32'd1);
    chk("b2b_gap_ready", 32'(ready), 32'd1);
    @(negedge clock);
    chk("b2b_f2_busy", 32'(busy), 32'd1);
    chk("b2b_f2_start", 32'(serial_out), 32'd0);
    valid = 1'b0;
    capture(-1, lv2, dk2, rh);
    chk("b2b_f2_data", 32'(lv2[8:1]), 32'hFF);
    chk("b2b_f2_len", 32'(dk2), 32'(FL));

    @(negedge clock);
    valid = 1'b1;
    data  = 8'($urandom);
    @(negedge clock);
    valid = 1'b0;
    repeat (DIV * 4 + 1) @(negedge clock);
    reset_L = 1'b0;
    @(negedge clock);
    reset_L = 1'b1;
    chk("abort_serial", 32'(serial_out), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    cnt_done = 0;
    cnt_low  = 0;
    for (int i = 0; i < 3 * FL; i++) begin
      @(negedge clock);
      if (done) cnt_done++;
      if (!serial_out) cnt_low++;
    end
    chk("abort_no_done", 32'(cnt_done), 32'd0);
    chk("abort_line_high", 32'(cnt_low), 32'd0);

    @(negedge clock);
    valid1 = 1'b1;
    data1  = 8'h80;
    @(negedge clock);
    valid1 = 1'b0;
    chk("div1_busy", 32'(busy1), 32'd1);
    lv1 = '0;
    for (int k = 0; k < NB; k++) begin
      lv1[k] = serial_out1;
      if (k == NB - 1) chk("div1_done_early", 32'(done1), 32'd0);
      @(negedge clock);
    end
    chk("div1_levels", 32'(lv1), 32'(DIV1_EXP));
    chk("div1_done", 32'(done1), 32'd1);

    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      valid   = ($urandom_range(0, 2) == 0);
      data    = 8'($urandom);
      reset_L = ($urandom_range(0, 399) != 0);
    end
    valid   = 1'b0;
    reset_L = 1'b1;
    repeat (FL + 4) @(negedge clock);
    chk("done_count", 32'(dut_dones), 32'(m_frames));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
